// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, sequencer states and latency helpers
// shared by the FPU issue/complete sequencer slice.
package fpu_pkg;

  typedef enum logic [3:0] {
    FADD   = 4'd0,
    FSUB   = 4'd1,
    FMUL   = 4'd2,
    FDIV   = 4'd3,
    FSQRT  = 4'd4,
    FSGNJ  = 4'd5,
    FSGNJN = 4'd6,
    FSGNJX = 4'd7,
    FEQ    = 4'd8,
    FLE    = 4'd9,
    FLT    = 4'd10,
    FCVTWS = 4'd11,
    FCVTSW = 4'd12
  } fpuop_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  localparam int unsigned LAT_ADD_DEF  = 3;
  localparam int unsigned LAT_MUL_DEF  = 3;
  localparam int unsigned LAT_DIV_DEF  = 10;
  localparam int unsigned LAT_SQRT_DEF = 7;
  localparam int unsigned LAT_MISC_DEF = 1;
  localparam int unsigned LAT_MAX_DEF  = 10;

  function automatic int unsigned lat_max(
    input int unsigned l_add,
    input int unsigned l_mul,
    input int unsigned l_div,
    input int unsigned l_sqrt,
    input int unsigned l_misc
  );
    int unsigned m;
    m = l_add;
    if (l_mul > m)  m = l_mul;
    if (l_div > m)  m = l_div;
    if (l_sqrt > m) m = l_sqrt;
    if (l_misc > m) m = l_misc;
    return m;
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > FCVTSW;
  endfunction

  function automatic int unsigned lat_of(
    input logic [3:0]  op,
    input int unsigned l_add,
    input int unsigned l_mul,
    input int unsigned l_div,
    input int unsigned l_sqrt,
    input int unsigned l_misc
  );
    int unsigned l;
    l = 1;
    case (op)
      FADD, FSUB: l = l_add;
      FMUL:       l = l_mul;
      FDIV:       l = l_div;
      FSQRT:      l = l_sqrt;
      FSGNJ, FSGNJN, FSGNJX,
      FEQ, FLE, FLT,
      FCVTWS, FCVTSW: l = l_misc;
      default:    l = 1;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/fpu_seq_if.sv
// fpu_seq_if: request/response valid-ready channels
// between an issuing core and the FPU sequencer.
interface fpu_seq_if #(
  parameter int W    = 32,
  parameter int TAGW = 5
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [W-1:0]    req_src0;
  logic [W-1:0]    req_src1;
  logic [TAGW-1:0] req_tag;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  modport master (
    output req_valid, req_op, req_src0,
    output req_src1, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_src0,
    input  req_src1, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_tag, rsp_err
  );
endinterface

// File: rtl/fpu_lat_cnt.sv
// fpu_lat_cnt: loadable down-counter with zero flag
// that times the in-flight FPU operation.
module fpu_lat_cnt #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: issues one FP op to the unit bank, waits the
// per-op latency and returns the selected result.
module fpu_seq
  import fpu_pkg::*;
#(
  parameter int unsigned W        = 32,
  parameter int unsigned TAGW     = 5,
  parameter int unsigned LAT_ADD  = LAT_ADD_DEF,
  parameter int unsigned LAT_MUL  = LAT_MUL_DEF,
  parameter int unsigned LAT_DIV  = LAT_DIV_DEF,
  parameter int unsigned LAT_SQRT = LAT_SQRT_DEF,
  parameter int unsigned LAT_MISC = LAT_MISC_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  fpu_seq_if.slave     bus,
  output logic [3:0]   u_op,
  output logic [W-1:0] u_src0,
  output logic [W-1:0] u_src1,
  input  logic [W-1:0] add_res,
  input  logic [W-1:0] sub_res,
  input  logic [W-1:0] mul_res,
  input  logic [W-1:0] div_res,
  input  logic [W-1:0] sqrt_res,
  input  logic [W-1:0] misc_res,
  output logic         busy
);

  localparam int unsigned LAT_MAX =
    lat_max(LAT_ADD, LAT_MUL, LAT_DIV, LAT_SQRT, LAT_MISC);
  localparam int unsigned CW = $clog2(LAT_MAX + 1);

  if (LAT_ADD < 1 || LAT_MUL < 1 || LAT_DIV < 1 ||
      LAT_SQRT < 1 || LAT_MISC < 1) begin : g_lat_chk
    $error("fpu_seq: every LAT_* must be >= 1");
  end

  seq_state_e      r_state;
  seq_state_e      w_state_nxt;
  logic [3:0]      r_op;
  logic [W-1:0]    r_src0;
  logic [W-1:0]    r_src1;
  logic [TAGW-1:0] r_tag;
  logic [W-1:0]    r_data;
  logic            r_err;

  logic            w_accept;
  logic            w_dec;
  logic            w_cap;
  logic            w_zero;
  logic [CW-1:0]   w_ld_val;
  logic [W-1:0]    w_res;

  // Same-edge consume+accept keeps DONE->EXEC bubble-free.
  assign bus.req_ready = !flush &&
    ((r_state == S_IDLE) ||
     ((r_state == S_DONE) && bus.rsp_ready));

  assign w_accept = bus.req_valid && bus.req_ready;

  assign w_ld_val = CW'(lat_of(bus.req_op, LAT_ADD, LAT_MUL,
                               LAT_DIV, LAT_SQRT, LAT_MISC) - 1);

  fpu_lat_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_accept),
    .i_load_val (w_ld_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      (r_op == FADD):  w_res = add_res;
      (r_op == FSUB):  w_res = sub_res;
      (r_op == FMUL):  w_res = mul_res;
      (r_op == FDIV):  w_res = div_res;
      (r_op == FSQRT): w_res = sqrt_res;
      (r_op >= FSGNJ && r_op <= FCVTSW):
                       w_res = misc_res;
      default:         w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dec       = 1'b0;
    w_cap       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (!w_zero) begin
          w_dec = 1'b1;
        end else begin
          w_cap       = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (bus.rsp_ready) begin
          w_state_nxt = w_accept ? S_EXEC : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_src0  <= '0;
      r_src1  <= '0;
      r_tag   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= bus.req_op;
        r_src0 <= bus.req_src0;
        r_src1 <= bus.req_src1;
        r_tag  <= bus.req_tag;
      end
      if (w_cap) begin
        r_data <= w_res;
        r_err  <= is_illegal(r_op);
      end
    end
  end

  assign u_op          = r_op;
  assign u_src0        = r_src0;
  assign u_src1        = r_src1;
  assign bus.rsp_valid = (r_state == S_DONE);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_tag   = r_tag;
  assign bus.rsp_err   = r_err;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: scoreboard bench for the FPU sequencer
// with a behavioural single-precision unit bank.
module tb_fpu_seq;
  localparam int W    = 32;
  localparam int TAGW = 5;

  logic         clk   = 1'b0;
  logic         rstn  = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   u_op;
  logic [W-1:0] u_src0, u_src1;
  logic [W-1:0] add_res, sub_res, mul_res;
  logic [W-1:0] div_res, sqrt_res, misc_res;
  logic         busy;

  fpu_seq_if #(.W(W), .TAGW(TAGW)) bus ();

  fpu_seq #(.W(W), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .bus      (bus),
    .u_op     (u_op),
    .u_src0   (u_src0),
    .u_src1   (u_src1),
    .add_res  (add_res),
    .sub_res  (sub_res),
    .mul_res  (mul_res),
    .div_res  (div_res),
    .sqrt_res (sqrt_res),
    .misc_res (misc_res),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]    data;
    logic [TAGW-1:0] tag;
    logic            err;
    int              due;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_rsp = 0;
  int   first_v = 0;
  logic pend = 1'b0;
  logic [W-1:0]    last_data = '0;
  logic [TAGW-1:0] last_tag  = '0;
  logic            last_err  = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic real sp2r(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:0] == 31'd0) return 0.0;
    e = int'(x[30:23]) - 127;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real v);
    logic        s;
    int          e;
    real         m;
    logic [22:0] f;
    if (v == 0.0 || v != v) return 32'h0;
    if (v > 1.0e38 || v < -1.0e38) return 32'h0;
    s = (v < 0.0);
    m = s ? -v : v;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] f_div(input logic [31:0] a,
                                        input logic [31:0] b);
    if (b[30:0] == 31'd0) return 32'h0;
    return r2sp(sp2r(a) / sp2r(b));
  endfunction

  function automatic logic [31:0] f_sqrt(input logic [31:0] a);
    return r2sp($sqrt(sp2r({1'b0, a[30:0]})));
  endfunction

  always_comb begin
    add_res  = r2sp(sp2r(u_src0) + sp2r(u_src1));
    sub_res  = r2sp(sp2r(u_src0) - sp2r(u_src1));
    mul_res  = r2sp(sp2r(u_src0) * sp2r(u_src1));
    div_res  = f_div(u_src0, u_src1);
    sqrt_res = f_sqrt(u_src0);
    misc_res = {u_src1[31], u_src0[30:0]};
  end

  function automatic logic [31:0] exp_of(input logic [3:0]  op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    if (op == 4'd0) return r2sp(sp2r(a) + sp2r(b));
    if (op == 4'd1) return r2sp(sp2r(a) - sp2r(b));
    if (op == 4'd2) return r2sp(sp2r(a) * sp2r(b));
    if (op == 4'd3) return f_div(a, b);
    if (op == 4'd4) return f_sqrt(a);
    if (op <= 4'd12) return {b[31], a[30:0]};
    return 32'h0;
  endfunction

  function automatic int lat_ref(input logic [3:0] op);
    if (op <= 4'd1) return 3;
    if (op == 4'd2) return 3;
    if (op == 4'd3) return 10;
    if (op == 4'd4) return 7;
    return 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rstn) begin
      pend = 1'b0;
    end else begin
      if (bus.rsp_valid && !pend) begin
        pend    = 1'b1;
        first_v = cyc;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp_t e;
        pend = 1'b0;
        if (q.size() == 0) begin
          check("spurious_rsp", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_tag", bus.rsp_tag, e.tag);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_lat", first_v, e.due);
          last_data = bus.rsp_data;
          last_tag  = bus.rsp_tag;
          last_err  = bus.rsp_err;
          n_rsp++;
        end
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic issue(input logic [3:0]      op,
                       input logic [31:0]     a,
                       input logic [31:0]     b,
                       input logic [TAGW-1:0] tag,
                       output int             stalls);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_src0  = a;
    bus.req_src1  = b;
    bus.req_tag   = tag;
    stalls = 0;
    @(negedge clk);
    while (!bus.req_ready && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.data = exp_of(op, a, b);
      e.tag  = tag;
      e.err  = (op > 4'd12);
      e.due  = cyc + 1 + lat_ref(op);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]      op;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [TAGW-1:0] tag;
  } stim_t;

  stim_t tbl[$] = '{
    '{4'd1,  32'h40A00000, 32'h3F800000, 5'd20},
    '{4'd4,  32'h41100000, 32'h00000000, 5'd21},
    '{4'd8,  32'h3F800000, 32'hBF800000, 5'd22},
    '{4'd12, 32'hC0400000, 32'h40000000, 5'd23},
    '{4'd13, 32'h40400000, 32'h40000000, 5'd24},
    '{4'd2,  32'h3FC00000, 32'h40800000, 5'd25}
  };

  initial begin
    int st;
    int n;
    int n0;
    int seen;
    logic [W-1:0] d0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_src0  = '0;
    bus.req_src1  = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;

    #12;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_u_op", u_op, 0);
    check("rst_u_src0", u_src0, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_tag", bus.rsp_tag, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    #11 rstn = 1'b1;
    @(posedge clk);
    #1;

    issue(4'd0, 32'h3F800000, 32'h40000000, 5'd7, st);
    drain();
    check("fadd_data", last_data, 32'h40400000);
    check("fadd_tag", last_tag, 7);
    check("fadd_err", last_err, 0);

    issue(4'd3, 32'h40C00000, 32'h40000000, 5'd1, st);
    issue(4'd5, 32'h40000000, 32'hBF800000, 5'd2, st);
    check("div_stall_cycles", st, 10);
    drain();
    check("sgnj_data", last_data, 32'hC0000000);

    bus.rsp_ready = 1'b0;
    issue(4'd2, 32'h40400000, 32'h40000000, 5'd4, st);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("bp_valid_seen", bus.rsp_valid, 1);
    d0 = bus.rsp_data;
    check("bp_data", d0, 32'h40C00000);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_data", bus.rsp_data, 32'h40C00000);
      check("bp_hold_tag", bus.rsp_tag, 4);
      check("bp_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    n0 = n_rsp;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_valid_drop", bus.rsp_valid, 0);
    check("bp_one_handshake", n_rsp - n0, 1);
    @(posedge clk);
    #1;

    issue(4'hF, 32'h40400000, 32'h40000000, 5'd3, st);
    drain();
    check("ill_data", last_data, 0);
    check("ill_err", last_err, 1);
    check("ill_tag", last_tag, 3);

    foreach (tbl[i]) issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, st);
    drain();
    check("tbl_last_data", last_data, 32'h40C00000);

    issue(4'd4, 32'h40800000, 32'h00000000, 5'd9, st);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_req_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    q.delete();
    check("flush_busy", busy, 0);
    check("flush_valid", bus.rsp_valid, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("flush_no_rsp", seen, 0);
    @(posedge clk);
    #1;
    issue(4'd0, 32'h3F000000, 32'h3E800000, 5'd10, st);
    drain();
    check("post_flush_data", last_data, 32'h3F400000);
    check("post_flush_tag", last_tag, 10);

    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd0;
    @(negedge clk);
    check("idle_flush_ready", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check("idle_flush_busy", busy, 0);
    flush         = 1'b0;
    bus.req_valid = 1'b0;

    issue(4'd3, 32'h41000000, 32'h40000000, 5'd11, st);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", bus.rsp_valid, 0);
    check("arst_cnt", dut.u_cnt.r_cnt, 0);
    q.delete();
    #13 rstn = 1'b1;
    @(posedge clk);
    #1;
    check("arst_req_ready", bus.req_ready, 1);
    issue(4'd2, 32'h3FC00000, 32'h40000000, 5'd12, st);
    drain();
    check("arst_new_data", last_data, 32'h40400000);
    check("arst_new_tag", last_tag, 12);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
Parametrised FPU issue/complete sequencer, the successor to the current fixed-latency FPU control. Accepts one FP op per valid/ready handshake and registers the operands, opcode and tag. Drives an external unit bank, counts a per-op latency set by parameters, and captures the selected unit result. Returns it over a valid/ready response channel with tag, error flag, flush and back-to-back issue.

Parameters:
W, 32, operand/result width
TAGW, 5, request tag width
LAT_ADD, 3, fadd/fsub latency in cycles (>=1)
LAT_MUL, 3, fmul latency (>=1)
LAT_DIV, 10, fdiv latency (>=1)
LAT_SQRT, 7, fsqrt latency (>=1)
LAT_MISC, 1, latency of ops 5..12: sgnj*, feq/fle/flt, fcvt* (>=1)

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock; reset is asynchronous and active-low
flush  in  1  synchronous abort of the in-flight op
req_valid  in  1  request valid
req_ready  out  1  request ready
req_op  in  4  opcode, fpu_pkg::fpuop_e
req_src0  in  W  operand 0
req_src1  in  W  operand 1
req_tag  in  TAGW  request tag
u_op  out  4  registered opcode to the unit bank
u_src0  out  W  registered operand 0 to the unit bank
u_src1  out  W  registered operand 1 to the unit bank
add_res, sub_res, mul_res, div_res, sqrt_res, misc_res  in  W each  unit results
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_data  out  W  result
rsp_tag  out  TAGW  tag of the request
rsp_err  out  1  illegal opcode (13..15)
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; u_op, u_src*, rsp_data, rsp_tag, rsp_err, counter all 0. Outputs after reset: rsp_valid=0, req_ready=1, busy=0.
- FSM states: IDLE, EXEC, DONE.
- req_ready = !flush && (IDLE || (DONE && rsp_ready)). This allows same-cycle response consume plus new accept.
- Accept at edge E0 (req_valid && req_ready):
  - Latch u_op/u_src*/tag.
  - Load counter with L-1, where L = the latency for req_op.
  - Go to EXEC.
  - u_* stay stable until the next accept.
- Opcode mapping:
  - 0,1 -> LAT_ADD
  - 2 -> LAT_MUL
  - 3 -> LAT_DIV
  - 4 -> LAT_SQRT
  - 5..12 -> LAT_MISC
  - 13..15 -> illegal: L=1, captured data=0, rsp_err=1.
- EXEC edge: if counter!=0, decrement. Else capture the result mux into rsp_data and go to DONE. The capture edge is E_L.
  - Result mux: 0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5..12 misc_res, else 0.
  - rsp_valid is high L cycles after the accept edge.
- DONE: rsp_valid=1; rsp_data/tag/err held stable while rsp_ready=0.
  - On rsp_ready: go to IDLE, or to EXEC if a new request is accepted on the same edge.
- flush:
  - In EXEC or DONE: go to IDLE next edge; no response is emitted; rsp_valid drops next cycle.
  - In IDLE: no effect.
  - Flush beats accept: req_ready=0 while flush=1.
- Async reset mid-op: immediate return to the reset state; the op is lost.
- Counter width: $clog2(max latency parameter + 1). Elaboration error if any LAT_* < 1.
- Unit bank contract: a unit with latency L presents a valid result at edge E_L given operands stable from E0.

Decomposition:
- fpu_pkg holds:
  - fpuop_e enum: FADD=0 .. FCVTSW=12.
  - Function lat_of(op, params) returning L.
  - Function is_illegal(op).
  - Localparam for the max latency.
- One sub-module: fpu_lat_cnt, a loadable down-counter with async reset and a zero flag, parametrised by width.

Test Plan:
- FADD 0x3F800000 + 0x40000000, tag 7, rsp_ready=1 -> rsp_valid exactly 3 cycles after accept, rsp_data=0x40400000 (bench unit model), rsp_tag=7, rsp_err=0.
- FDIV (op 3) with LAT_DIV=10, then FSGNJ (op 5) offered while busy -> req_ready=0 for 10 cycles. The div response appears at cycle 10; sgnj is accepted on the response edge and returns 1 cycle later.
- Backpressure: FMUL result 0x40C00000 with rsp_ready low 5 cycles -> rsp_valid, data and tag stable all 5 cycles, req_ready=0. Release -> one handshake only.
- Illegal op 4'hF, tag 3 -> rsp_valid 1 cycle after accept, rsp_data=0, rsp_err=1, rsp_tag=3.
- Flush at cycle 4 of FSQRT (LAT 7) -> state IDLE next edge, no rsp_valid ever for that tag. Next FADD completes normally in 3 cycles.
- rstn pulsed low asynchronously mid-FDIV -> busy, rsp_valid and the counter clear immediately. After release, req_ready=1 and a new op completes with correct latency.
